// File: rtl/be8_sequencer_if.sv
// Decoder-facing signal bundle of the BE8 sequencer.
// Optional single-step inputs appear only when BE8_SINGLE_STEP_EN is defined.
interface be8_sequencer_if;
    logic       ena;
    logic [7:0] bus_in;
    logic       alu_carry;
    logic       alu_zero;
    logic       hlt;
    logic       ir_in_n;
    logic       fi_n;
    logic       next_n;
    logic       resume;
`ifdef BE8_SINGLE_STEP_EN
    logic       step_mode;
    logic       step_req;
`endif
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [1:0] flags;
    logic [1:0] step;
    logic       halted;
    logic       instr_done;
    logic [7:0] instr_count;

    // Strobes carry no valid/ready exchange: the sequencer samples them on every
    // active edge and always accepts; outputs are valid every cycle out of reset.
    modport master (
`ifdef BE8_SINGLE_STEP_EN
        input  step_mode,
        input  step_req,
`endif
        input  ena,
        input  bus_in,
        input  alu_carry,
        input  alu_zero,
        input  hlt,
        input  ir_in_n,
        input  fi_n,
        input  next_n,
        input  resume,
        output opcode,
        output operand,
        output flags,
        output step,
        output halted,
        output instr_done,
        output instr_count
    );

    modport slave (
`ifdef BE8_SINGLE_STEP_EN
        output step_mode,
        output step_req,
`endif
        output ena,
        output bus_in,
        output alu_carry,
        output alu_zero,
        output hlt,
        output ir_in_n,
        output fi_n,
        output next_n,
        output resume,
        input  opcode,
        input  operand,
        input  flags,
        input  step,
        input  halted,
        input  instr_done,
        input  instr_count
    );
endinterface

// File: rtl/be8_sequencer.sv
// BE8 front-end sequencer: IR, flags, microstep counter, halt latch, instruction counter.
// Optional BE8_SINGLE_STEP_EN adds a synchronised single-step gate on active edges.
module be8_sequencer #(
    parameter int unsigned STEP_LAST = 3,
    parameter logic [7:0]  RESET_IR  = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    be8_sequencer_if.master sif,
    output logic [0:0]      dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_e;

    localparam logic [1:0] STEP_LAST_V = 2'(STEP_LAST);

    run_state_e state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] flags_q, flags_d;
    logic [1:0] step_q, step_d;
    logic       done_q, done_d;
    logic [7:0] count_q, count_d;
    logic       boundary;
    logic       step_gate;

`ifdef BE8_SINGLE_STEP_EN
    logic req_s1, req_s2, req_s3;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_s3 <= 1'b0;
        end else begin
            req_s1 <= sif.step_req;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
        end
    end

    assign step_gate = !sif.step_mode || (req_s2 && !req_s3);
`else
    assign step_gate = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ir_q    <= RESET_IR;
            flags_q <= 2'b00;
            step_q  <= 2'd0;
            done_q  <= 1'b0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            step_q  <= step_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        flags_d  = flags_q;
        step_d   = step_q;
        boundary = 1'b0;
        if (sif.ena) begin
            case (state_q)
                ST_RUN: begin
                    if (step_gate) begin
                        // Register loads happen alongside halt or boundary on the same edge.
                        if (!sif.ir_in_n) ir_d = sif.bus_in;
                        if (!sif.fi_n) flags_d = {sif.alu_carry, sif.alu_zero};
                        if (sif.hlt) begin
                            state_d = ST_HALT;
                        end else if (!sif.next_n || step_q == STEP_LAST_V) begin
                            step_d   = 2'd0;
                            boundary = 1'b1;
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end
                end
                ST_HALT: begin
                    if (sif.resume) begin
                        state_d = ST_RUN;
                        step_d  = 2'd0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        done_d  = boundary;
        count_d = count_q + {7'd0, boundary};
    end

    assign sif.opcode      = ir_q[7:4];
    assign sif.operand     = ir_q[3:0];
    assign sif.flags       = flags_q;
    assign sif.step        = step_q;
    assign sif.halted      = (state_q == ST_HALT);
    assign sif.instr_done  = done_q;
    assign sif.instr_count = count_q;
    assign dbg_state       = 1'(state_q);

endmodule

// File: tb/tb_be8_sequencer.sv
// Directed bench for be8_sequencer with a cycle-level reference model and literal anchors.
module tb_be8_sequencer;
    localparam int STEP_LAST = 3;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n;
    logic [0:0] dbg_state;

    be8_sequencer_if sif();

    be8_sequencer #(.STEP_LAST(STEP_LAST), .RESET_IR(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sif       (sif.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 if (clk_run) clk = ~clk;

    // ---------------- reference model ----------------
    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;
    logic [7:0] m_ir;
    logic [1:0] m_flags;
    int         m_step;
    logic       m_halted;
    logic       m_done;
    logic [7:0] m_count;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ir = 8'h00; m_flags = 2'b00; m_step = 0;
        m_halted = 1'b0; m_done = 1'b0; m_count = 8'h00;
    endtask

    // Position within an instruction advances modulo (STEP_LAST+1); reaching 0 is a boundary.
    task automatic model_edge();
        m_done = 1'b0;
        if (sif.ena && m_halted) begin
            if (sif.resume) begin
                m_halted = 1'b0;
                m_step = 0;
            end
        end else if (sif.ena) begin
            if (!sif.ir_in_n) m_ir = sif.bus_in;
            if (!sif.fi_n) m_flags = {sif.alu_carry, sif.alu_zero};
            if (sif.hlt) begin
                m_halted = 1'b1;
            end else begin
                m_step = sif.next_n ? (m_step + 1) % (STEP_LAST + 1) : 0;
                if (m_step == 0) begin
                    m_done = 1'b1;
                    m_count = m_count + 8'd1;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        sif.ena = 1'b1; sif.bus_in = 8'h00; sif.alu_carry = 1'b0; sif.alu_zero = 1'b0;
        sif.hlt = 1'b0; sif.ir_in_n = 1'b1; sif.fi_n = 1'b1; sif.next_n = 1'b1;
        sif.resume = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
        #1;
        set_idle();
    endtask

    task automatic expect_state(input string tag, input logic [1:0] st, input logic [7:0] cnt,
                                input logic dn, input logic hl);
        check({tag, "_step"}, 8'(sif.step), 8'(st));
        check({tag, "_count"}, sif.instr_count, cnt);
        check({tag, "_done"}, 8'(sif.instr_done), 8'(dn));
        check({tag, "_halted"}, 8'(sif.halted), 8'(hl));
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_opcode", 8'(sif.opcode), 8'(m_ir[7:4]));
            check("cmp_operand", 8'(sif.operand), 8'(m_ir[3:0]));
            check("cmp_flags", 8'(sif.flags), 8'(m_flags));
            check("cmp_step", 8'(sif.step), 8'(m_step));
            check("cmp_halted", 8'(sif.halted), 8'(m_halted));
            check("cmp_done", 8'(sif.instr_done), 8'(m_done));
            check("cmp_count", sif.instr_count, m_count);
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] free_steps [8];

    initial begin
        free_steps = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef BE8_SINGLE_STEP_EN
        sif.step_mode = 1'b0;
        sif.step_req = 1'b0;
`endif
        set_idle();
        // Strobes asserted during reset must have no effect.
        sif.ir_in_n = 1'b0; sif.bus_in = 8'hFF; sif.fi_n = 1'b0; sif.alu_carry = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_opcode", 8'(sif.opcode), 8'h00);
        check("rst_flags", 8'(sif.flags), 8'h00);
        expect_state("rst", 2'd0, 8'h00, 1'b0, 1'b0);
        set_idle();
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // Free run: step 0,1,2,3,0,1,2,3 before each edge.
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("free_step", 8'(sif.step), 8'(free_steps[i]));
            check("free_done", 8'(sif.instr_done), 8'(free_steps[i] == 2'd0));
        end
        expect_state("free_end", 2'd0, 8'd2, 1'b1, 1'b0);

        // IR load at step 1.
        cycle();
        sif.ir_in_n = 1'b0; sif.bus_in = 8'h5A;
        cycle();
        check("ir_opcode", 8'(sif.opcode), 8'h05);
        check("ir_operand", 8'(sif.operand), 8'h0A);
        check("ir_step", 8'(sif.step), 8'd2);

        // Flags loads.
        sif.fi_n = 1'b0; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
        cycle();
        check("flags_c", 8'(sif.flags), 8'b10);
        expect_state("flags_c", 2'd3, 8'd2, 1'b0, 1'b0);
        cycle();
        expect_state("wrap3", 2'd0, 8'd3, 1'b1, 1'b0);
        sif.fi_n = 1'b0; sif.alu_carry = 1'b0; sif.alu_zero = 1'b1;
        cycle();
        check("flags_z", 8'(sif.flags), 8'b01);
        expect_state("flags_z", 2'd1, 8'd3, 1'b0, 1'b0);

        // resume while running is ignored; next_n at step 2 then at step 3.
        sif.resume = 1'b1;
        cycle();
        check("resume_ign", 8'(sif.step), 8'd2);
        sif.next_n = 1'b0;
        cycle();
        expect_state("next_s2", 2'd0, 8'd4, 1'b1, 1'b0);
        cycle();
        check("done_pulse", 8'(sif.instr_done), 8'd0);
        cycle();
        cycle();
        check("pre_s3", 8'(sif.step), 8'd3);
        sif.next_n = 1'b0;
        cycle();
        expect_state("next_s3", 2'd0, 8'd5, 1'b1, 1'b0);

        // Halt at step 2 with concurrent IR load.
        cycle();
        cycle();
        sif.hlt = 1'b1; sif.ir_in_n = 1'b0; sif.bus_in = 8'h3C;
        cycle();
        check("hlt_ir", {sif.opcode, sif.operand}, 8'h3C);
        expect_state("hlt", 2'd2, 8'd5, 1'b0, 1'b1);
        check("hlt_dbg", 8'(dbg_state), 8'd1);
        for (int i = 0; i < 10; i++) begin
            sif.hlt = 1'b1; sif.next_n = 1'b0; sif.ir_in_n = 1'b0; sif.bus_in = 8'hFF;
            sif.fi_n = 1'b0; sif.alu_carry = 1'b1; sif.alu_zero = 1'b1;
            cycle();
            check("halt_step", 8'(sif.step), 8'd2);
        end
        check("halt_ir", {sif.opcode, sif.operand}, 8'h3C);
        check("halt_flags", 8'(sif.flags), 8'b01);
        sif.resume = 1'b1;
        cycle();
        expect_state("resume", 2'd0, 8'd5, 1'b0, 1'b0);

        // ena=0 holds everything and suppresses instr_done.
        cycle();
        for (int i = 0; i < 3; i++) begin
            sif.ena = 1'b0; sif.next_n = 1'b0; sif.ir_in_n = 1'b0; sif.bus_in = 8'h77;
            sif.hlt = 1'b1; sif.fi_n = 1'b0;
            cycle();
        end
        expect_state("ena0", 2'd1, 8'd5, 1'b0, 1'b0);
        check("ena0_ir", {sif.opcode, sif.operand}, 8'h3C);
        sif.next_n = 1'b0;
        cycle();
        expect_state("ena1_next", 2'd0, 8'd6, 1'b1, 1'b0);
        sif.ena = 1'b0;
        cycle();
        check("ena0_done", 8'(sif.instr_done), 8'd0);

        // Counter wrap.
        for (int i = 0; i < 300 && m_count != 8'hFF; i++) begin
            sif.next_n = 1'b0;
            cycle();
        end
        check("count_ff", sif.instr_count, 8'hFF);
        sif.next_n = 1'b0;
        cycle();
        expect_state("count_wrap", 2'd0, 8'h00, 1'b1, 1'b0);

        // Mid-step asynchronous reset with the clock stopped.
        cycle();
        cycle();
        check("pre_rst_step", 8'(sif.step), 8'd2);
        chk_en = 1'b0;
        @(negedge clk);
        clk_run = 1'b0;
        #12;
        rst_n = 1'b0;
        #1;
        check("arst_clk_low", 8'(clk), 8'd0);
        check("arst_ir", {sif.opcode, sif.operand}, 8'h00);
        check("arst_flags", 8'(sif.flags), 8'h00);
        expect_state("arst", 2'd0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
